fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit, 32-deep synchronous FIFO. It pops bytes through the FIFO read port and serialises each one as a UART frame on `tx`: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It runs on the FIFO clock and provides the board-level serial output path.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, used only when PARITY_EN=1; 0 = even parity, 1 = odd parity
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clock  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = fetching of new bytes allowed
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO data_out; valid the cycle after the FIFO samples rd=1
fifo_rd  output  1  FIFO read strobe, registered, one-cycle pulse
tx  output  1  UART serial line, idle high, registered
busy  output  1  1 whenever state != IDLE
frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Interface: one clock, `clock`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, fifo_rd=0, busy=0, frame_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame: tx returns to 1 on the next edge. The in-flight byte is dropped and no further fifo_rd is issued.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If en=1 and fifo_empty=0 at an edge, go to FETCH and fifo_rd=1 for the following cycle.
- FETCH: lasts 1 cycle, with fifo_rd=1. Next state is LOAD, and fifo_rd returns to 0.
  - fifo_empty is ignored in FETCH and LOAD.
  - Exactly one pop is issued per frame. fifo_rd is never high in two consecutive cycles.
- LOAD: lasts 1 cycle. The shift register captures fifo_data at the end of this cycle. Parity is computed from the captured byte (XOR of the 8 bits, inverted when PARITY_ODD=1).
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: shifts out the 8 bits LSB first. Each bit is held for exactly CLKS_PER_BIT cycles; the bit index runs 0..7.
- PARITY: entered only if PARITY_EN=1. Holds the parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 in the last cycle of this state.
  - Next state is IDLE.
- Timing: if fifo_rd is high in cycle k, tx is low from cycle k+2. Minimum idle-high gap between back-to-back frames is stop time + 3 cycles (IDLE, FETCH, LOAD).
- Frame length, start bit through last stop bit: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at every bit boundary and is cleared in IDLE.
- en deasserted mid-frame: the current frame completes; only new fetches are blocked. en deasserted in FETCH or LOAD: the pop is already committed and the frame is still sent.
- FIFO empty: the block stays in IDLE with tx=1, and fifo_rd is never asserted.
- FIFO upstream writes during a frame: no effect until the frame returns to IDLE.

Test Plan:
- Single byte (CLKS_PER_BIT=4, defaults): write 0xA5, en=1.
  - Expect one fifo_rd pulse, then tx low 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - tx high 4 cycles, frame_done on cycle 40 of the frame; busy low afterwards.
- Back-to-back: write 0x00, 0xFF, 0x3C → exactly 3 fifo_rd pulses and 3 frames in order. Gap from end of stop to next start is exactly 3 cycles. Final state IDLE with fifo_empty=1.
- Parity/stop options:
  - PARITY_EN=1, PARITY_ODD=0, byte 0xA5 → parity bit 0.
  - PARITY_ODD=1 → parity bit 1.
  - STOP_BITS=2 → stop high 8 cycles; frame length 48 cycles with parity.
- en gating: fill 2 bytes, en=0 → tx stays 1 and no fifo_rd. Drop en to 0 mid-first-frame → that frame completes and the second is not fetched. Raise en → second frame is sent.
- Reset mid-frame: assert rst during DATA bit 3 → next edge tx=1, busy=0, fifo_rd=0. After release with FIFO refilled (FIFO reset too), the next frame starts from the start bit.
- Empty-FIFO idle: en=1, nothing written for 1000 cycles → fifo_rd never asserted, tx constant 1, frame_done never pulses.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each one as a UART frame
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sr_q;
  logic          par_q, tx_q, rd_q, busy_q, done_q;
  logic          bit_end, last_stop, active;
  assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_stop = idx_q == 3'(STOP_BITS - 1);
  assign active    = state_q inside {START, DATA, PARITY, STOP};
  assign fifo_rd    = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  // frame sequencer: every output is a register updated on the state transitions
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= active ? (bit_end ? '0 : cnt_q + 1'b1) : '0;
      case (state_q)
        IDLE: if (en && !fifo_empty) begin
          state_q <= FETCH;
          rd_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          sr_q    <= fifo_data;
          par_q   <= ^fifo_data ^ (PARITY_ODD != 0);
          idx_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (bit_end) begin
          tx_q    <= sr_q[0];
          sr_q    <= sr_q >> 1;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_q   <= '0;
            tx_q    <= (PARITY_EN != 0) ? par_q : 1'b1;
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_q <= idx_q + 3'd1;
            tx_q  <= sr_q[0];
            sr_q  <= sr_q >> 1;
          end
        end
        PARITY: if (bit_end) begin
          tx_q    <= 1'b1;
          state_q <= STOP;
        end
        STOP: begin
          if (last_stop && cnt_q == CW'(CLKS_PER_BIT - 2)) done_q <= 1'b1;
          if (bit_end) begin
            idx_q   <= last_stop ? 3'd0 : idx_q + 3'd1;
            state_q <= last_stop ? IDLE : STOP;
            busy_q  <= !last_stop;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
